// File: rtl/sram_pkg.sv
// Shared defaults, response layout and request opcodes for the SRAM
// request front-end.
package sram_pkg;

  localparam int unsigned SRAM_WIDTH      = 8;
  localparam int unsigned SRAM_DEPTH      = 8;
  localparam int unsigned SRAM_ADDR_WIDTH = $clog2(SRAM_DEPTH);

  typedef struct packed {
    logic [SRAM_WIDTH-1:0]      data;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
  } sram_rsp_t;

  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

  // Credit counter must hold the value RSP_DEPTH itself.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO with a registered output stage; o_count covers
// both the storage array and the output register.
module sram_rsp_fifo
  import sram_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned W         = SRAM_WIDTH + SRAM_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_push_data,
  input  logic                         i_pop,
  output logic                         o_valid,
  output logic [W-1:0]                 o_data,
  output logic [$clog2(RSP_DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = credit_width(RSP_DEPTH);

  logic [W-1:0]  r_mem [RSP_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_mem_cnt;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;

  logic w_pop;
  logic w_load;

  // Output register refills from the array in the same cycle it is popped,
  // so consecutive entries leave without a gap.
  always_comb begin
    w_pop  = i_pop && r_out_valid;
    w_load = (r_mem_cnt != '0) && (!r_out_valid || w_pop);
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_load) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_out_data  <= r_mem[r_rd_ptr];
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
      case ({i_push, w_load})
        2'b10:   r_mem_cnt <= r_mem_cnt + CW'(1);
        2'b01:   r_mem_cnt <= r_mem_cnt - CW'(1);
        default: r_mem_cnt <= r_mem_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(i_push && (r_mem_cnt == CW'(RSP_DEPTH)) && !w_load))
        else $error("sram_rsp_fifo: push while full");
    end
  end

  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;
  assign o_count = r_mem_cnt + CW'(r_out_valid);

endmodule

// File: rtl/sram_req_ctrl.sv
// Request/response front-end for the single-port sram: registered SRAM drive,
// 2-stage read tracking and credit-gated in-order response FIFO.
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned WIDTH      = SRAM_WIDTH,
  parameter int unsigned DEPTH      = SRAM_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  sram_cs,
  output logic                  sram_re,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WIDTH-1:0]      sram_wdata,
  input  logic [WIDTH-1:0]      sram_rdata
);

  localparam int unsigned CW = credit_width(RSP_DEPTH);
  localparam int unsigned EW = WIDTH + ADDR_WIDTH;

  logic                  r_sram_cs;
  logic                  r_sram_re;
  logic                  r_sram_we;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [WIDTH-1:0]      r_sram_wdata;

  logic                  r_s1_valid;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic                  r_s2_valid;
  logic [ADDR_WIDTH-1:0] r_s2_addr;

  logic [CW-1:0]         r_credits;

  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_pop;
  logic                  w_fifo_valid;
  logic [EW-1:0]         w_fifo_data;
  logic [CW-1:0]         w_fifo_count;

  // Writes are gated by the same credit test as reads so ready never
  // depends on the opcode, but only reads consume a credit.
  always_comb begin
    w_req_ready = !reset && (r_credits != '0);
    w_accept    = req_valid && w_req_ready;
    w_wr_accept = w_accept && (req_we == REQ_WR);
    w_rd_accept = w_accept && (req_we == REQ_RD);
    w_pop       = w_fifo_valid && rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sram_cs    <= 1'b0;
      r_sram_re    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else begin
      r_sram_cs    <= w_accept;
      r_sram_re    <= w_rd_accept;
      r_sram_we    <= w_wr_accept;
      r_sram_addr  <= w_accept ? req_addr : '0;
      r_sram_wdata <= w_wr_accept ? req_wdata : '0;
    end
  end

  // Stage 2 lines up with the cycle in which sram_rdata holds the read word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_addr  <= '0;
    end else begin
      r_s1_valid <= w_rd_accept;
      r_s1_addr  <= w_rd_accept ? req_addr : '0;
      r_s2_valid <= r_s1_valid;
      r_s2_addr  <= r_s1_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_credits <= CW'(RSP_DEPTH);
    end else begin
      case ({w_rd_accept, w_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  sram_rsp_fifo #(
    .RSP_DEPTH (RSP_DEPTH),
    .W         (EW)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_s2_valid),
    .i_push_data ({sram_rdata, r_s2_addr}),
    .i_pop       (rsp_ready),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_count     (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (r_credits <= CW'(RSP_DEPTH))
        else $error("sram_req_ctrl: credit overflow");
      assert (int'(r_credits) + int'(w_fifo_count) + int'(r_s1_valid) + int'(r_s2_valid)
              == int'(RSP_DEPTH))
        else $error("sram_req_ctrl: credit accounting lost");
      assert (!w_accept || (int'(req_addr) < int'(DEPTH)))
        else $error("sram_req_ctrl: address beyond SRAM depth");
    end
  end

  assign req_ready  = w_req_ready;
  assign rsp_valid  = w_fifo_valid;
  assign rsp_data   = w_fifo_data[EW-1:ADDR_WIDTH];
  assign rsp_addr   = w_fifo_data[ADDR_WIDTH-1:0];
  assign sram_cs    = r_sram_cs;
  assign sram_re    = r_sram_re;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl wired to a behavioural single-port SRAM
// with one cycle of read latency and contents cleared by the shared reset.
module tb_sram_req_ctrl;
  import sram_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_addr;
  logic       sram_cs;
  logic       sram_re;
  logic       sram_we;
  logic [2:0] sram_addr;
  logic [7:0] sram_wdata;
  logic [7:0] sram_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sram_req_ctrl #(
    .WIDTH      (8),
    .DEPTH      (8),
    .ADDR_WIDTH (3),
    .RSP_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_addr   (rsp_addr),
    .sram_cs    (sram_cs),
    .sram_re    (sram_re),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  logic [7:0] mem [8];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      sram_rdata <= 8'h00;
    end else if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      if (sram_re) sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    n_cmp++;
    assert ((sram_re && sram_we) === 1'b0) else begin
      n_err++;
      $error("FAIL re_we_excl: observed re=%0b we=%0b expected not both", sram_re, sram_we);
    end
  endtask

  task automatic send(input logic we, input int unsigned addr, input int unsigned data);
    chk("send_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = 3'(addr);
    req_wdata = 8'(data);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int unsigned bound, output int unsigned lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < bound) begin
      tick();
      lat++;
    end
  endtask

  int unsigned lat;
  int unsigned n_acc;
  logic        seen;
  logic [7:0]  sexp [4];

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_rsp_addr", {29'd0, rsp_addr}, 32'd0);
    chk("rst_sram", {17'd0, sram_cs, sram_re, sram_we, sram_addr, sram_wdata}, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Write then read
    rsp_ready = 1'b1;
    send(REQ_WR, 4, 8'hAA);
    chk("wr_ctrl", {29'd0, sram_cs, sram_we, sram_re}, 32'b110);
    chk("wr_addr", {29'd0, sram_addr}, 32'd4);
    chk("wr_data", {24'd0, sram_wdata}, 32'hAA);
    send(REQ_RD, 4, 8'h5C);
    chk("rd_ctrl", {29'd0, sram_cs, sram_we, sram_re}, 32'b101);
    chk("rd_addr", {29'd0, sram_addr}, 32'd4);
    chk("rd_wdata_zero", {24'd0, sram_wdata}, 32'd0);
    wait_rsp(8, lat);
    chk("rd_latency", lat, 32'd3);
    chk("rd_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_data", {24'd0, rsp_data}, 32'hAA);
    chk("rd_rsp_addr", {29'd0, rsp_addr}, 32'd4);
    tick();
    chk("rd_popped", {31'd0, rsp_valid}, 32'd0);

    // Back-to-back read-after-write
    send(REQ_WR, 6, 8'h25);
    send(REQ_RD, 6, 8'h00);
    wait_rsp(8, lat);
    chk("raw_valid", {31'd0, rsp_valid}, 32'd1);
    chk("raw_data", {24'd0, rsp_data}, 32'h25);
    chk("raw_addr", {29'd0, rsp_addr}, 32'd6);
    tick();

    // Backpressure: only four reads fit
    for (int i = 0; i < 4; i++) send(REQ_WR, i, 8'h10 + i);
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_we = REQ_RD; req_addr = 3'(i);
      if (req_ready === 1'b1) n_acc++;
      tick();
    end
    req_valid = 1'b0;
    chk("bp_accepted", n_acc, 32'd4);
    chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
    repeat (4) tick();
    chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_hold_addr", {29'd0, rsp_addr}, 32'd0);
    chk("bp_hold_data", {24'd0, rsp_data}, 32'h10);
    chk("bp_still_full", {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_addr", {29'd0, rsp_addr}, 32'(k));
      chk("bp_data", {24'd0, rsp_data}, 32'h10 + 32'(k));
      tick();
      if (k == 0) chk("bp_ready_back", {31'd0, req_ready}, 32'd1);
    end
    chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

    // Streaming
    send(REQ_WR, 1, 8'hFF);
    send(REQ_WR, 2, 8'hDA);
    send(REQ_RD, 1, 0);
    send(REQ_RD, 2, 0);
    send(REQ_RD, 1, 0);
    send(REQ_RD, 2, 0);
    sexp[0] = 8'hFF; sexp[1] = 8'hDA; sexp[2] = 8'hFF; sexp[3] = 8'hDA;
    wait_rsp(8, lat);
    for (int k = 0; k < 4; k++) begin
      chk("st_valid", {31'd0, rsp_valid}, 32'd1);
      chk("st_data", {24'd0, rsp_data}, {24'd0, sexp[k]});
      tick();
    end
    chk("st_done", {31'd0, rsp_valid}, 32'd0);

    // Reset with two reads in flight
    send(REQ_RD, 4, 0);
    send(REQ_RD, 5, 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    chk("mid_rst_no_rsp", {31'd0, seen}, 32'd0);
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = REQ_RD; req_addr = 3'd4;
      if (req_ready === 1'b1) n_acc++;
      tick();
    end
    req_valid = 1'b0;
    chk("mid_rst_credits", n_acc, 32'd4);
    wait_rsp(8, lat);
    chk("mid_rst_rd_valid", {31'd0, rsp_valid}, 32'd1);
    chk("mid_rst_rd_data", {24'd0, rsp_data}, 32'h00);
    chk("mid_rst_rd_addr", {29'd0, rsp_addr}, 32'd4);
    rsp_ready = 1'b1;
    repeat (6) tick();
    chk("mid_rst_drained", {31'd0, rsp_valid}, 32'd0);

    // Idle
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_sram", {17'd0, sram_cs, sram_re, sram_we, sram_addr, sram_wdata}, 32'd0);
      chk("idle_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request/response front-end that sits directly upstream of the single-port `sram` block. It accepts read and write requests on a valid/ready stream and drives the SRAM's `chip_sel`, `read_ena`, `write_ena`, `address` and `data_in` pins, never asserting read and write together. It captures `data_out` at the SRAM's fixed read latency and returns read data, in order, on a valid/ready response stream through an internal response FIFO.

## Interface
Parameters:
- `WIDTH`, 8, data word width; must match `sram.WIDTH`.
- `DEPTH`, 8, SRAM word count; must match `sram.DEPTH`.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width.
- `RSP_DEPTH`, 4, response FIFO entries; power of two, minimum 2.

Ports (reset `reset`, synchronous, active-high; clock `clk`):
- `clk`, in, 1, clock; all logic on rising edge.
- `reset`, in, 1, synchronous active-high reset; shared with `sram`.
- `req_valid`, in, 1, request present.
- `req_ready`, out, 1, request accepted when high together with `req_valid`.
- `req_we`, in, 1, 1 = write, 0 = read.
- `req_addr`, in, ADDR_WIDTH, target address.
- `req_wdata`, in, WIDTH, write data; ignored for reads.
- `rsp_valid`, out, 1, read response present.
- `rsp_ready`, in, 1, consumer takes the response.
- `rsp_data`, out, WIDTH, read data.
- `rsp_addr`, out, ADDR_WIDTH, address of the returned read.
- `sram_cs`, out, 1, to `sram.chip_sel`.
- `sram_re`, out, 1, to `sram.read_ena`.
- `sram_we`, out, 1, to `sram.write_ena`.
- `sram_addr`, out, ADDR_WIDTH, to `sram.address`.
- `sram_wdata`, out, WIDTH, to `sram.data_in`.
- `sram_rdata`, in, WIDTH, from `sram.data_out`.

## Operation
- A request is accepted on edge E when `req_valid && req_ready`. One request is accepted per cycle at most, and there are no bubbles between back-to-back requests.
- The SRAM drive signals are registered. In the cycle after E:
  - For a write: `sram_cs=1`, `sram_we=1`, `sram_re=0`, plus `sram_addr` and `sram_wdata`.
  - For a read: `sram_cs=1`, `sram_re=1`, `sram_we=0`, `sram_addr`, and `sram_wdata=0`.
- In any cycle without an accepted request, all `sram_*` outputs are 0.
- Read tracking uses a 2-stage in-flight shift register holding (valid, addr). Stage 1 is loaded at E. At E+1 the entry moves to stage 2 while the SRAM samples. At E+2 `sram_rdata` is pushed with the address into the response FIFO.
- Credit counter: `credits = RSP_DEPTH − fifo_count − inflight_reads`.
  - `req_ready = !reset && credits != 0`.
  - The same gate applies to writes, so `req_ready` never depends on `req_we`.
  - Credits are restored on a response pop. A simultaneous pop and new read acceptance nets zero.
- Responses leave in issue order. Writes produce no response.
- Arithmetic: the credit counter is `$clog2(RSP_DEPTH)+1` bits wide. It never underflows (by the ready gate) and never exceeds `RSP_DEPTH` (assertion).
- Ordering: a write at E followed by a read of the same address at E+1 returns the new data, because the write commits at E+1 and the read samples at E+2.
- Reset:
  - `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_addr=0`, all `sram_*`=0.
  - FIFO emptied, in-flight stages cleared, credits = `RSP_DEPTH`.
  - A reset asserted mid-operation discards in-flight reads and queued responses, with no late push after reset. The SRAM contents are cleared by the shared reset.

## Timing
- Read latency: acceptance edge E → `rsp_valid` high after E+3, since the FIFO output is registered. Response data and address are stable while `rsp_valid && !rsp_ready`.
- Write commit: the SRAM cell is updated at edge E+1.
- Throughput: one request per cycle while `rsp_ready` is held high, once `RSP_DEPTH ≥ 4`.
- `req_ready` drops in the cycle after the last credit is consumed. It rises in the cycle after the pop edge.
- FIFO full or empty handling: a push when full cannot occur (credit scheme; assertion). A pop when empty is ignored.

## Structure
- Package `sram_pkg`: holds the `WIDTH`/`DEPTH` defaults, a `sram_rsp_t` struct (data, addr) and the `REQ_RD`/`REQ_WR` opcode constants.
- Sub-module `sram_rsp_fifo`: a synchronous FIFO with parameters `RSP_DEPTH` and entry width `WIDTH+ADDR_WIDTH`. It has a registered output, a count output, and synchronous reset.
- The top level contains the issue register, the in-flight pipe and the credit counter.
- `sram_req_ctrl` is instantiated beside `sram` in the bench, with its `sram_*` ports wired directly to the SRAM.

## Test plan
- **Write then read:** write 0xAA to address 4, then read address 4 with `rsp_ready=1` → `rsp_data=0xAA`, `rsp_addr=4`, `rsp_valid` 3 cycles after acceptance. `sram_re` and `sram_we` are never high together.
- **Back-to-back RAW:** write 0x25 to address 6 at E, then read address 6 at E+1 → returns 0x25.
- **Backpressure:** hold `rsp_ready=0` and issue 6 reads to addresses 0–5 → exactly 4 accepted, then `req_ready=0`. Release → responses for addresses 0,1,2,3 in order, and `req_ready` returns.
- **Streaming:** write 0xFF to address 1 and 0xDA to address 2, then read addresses 1,2,1,2 on consecutive cycles with `rsp_ready=1` → 0xFF, 0xDA, 0xFF, 0xDA with no gaps.
- **Reset mid-operation:** assert `reset` for one cycle with 2 reads in flight → no `rsp_valid` afterwards, credits back to 4, and a subsequent read of address 4 returns 0x00.
- **Idle:** with `req_valid=0` for 10 cycles → all `sram_*` outputs are 0 and `rsp_valid=0`.
